// File: rtl/mem_periph_pkg.sv
// Shared constants for the memory-mapped peripheral block: register offsets,
// TCON bit positions and register widths.
package mem_periph_pkg;

    localparam logic [31:0] OFF_TH      = 32'h0000_0000;
    localparam logic [31:0] OFF_TL      = 32'h0000_0004;
    localparam logic [31:0] OFF_TCON    = 32'h0000_0008;
    localparam logic [31:0] OFF_LED     = 32'h0000_000C;
    localparam logic [31:0] OFF_SWITCH  = 32'h0000_0010;
    localparam logic [31:0] OFF_DIGI    = 32'h0000_0014;
    localparam logic [31:0] OFF_SYSTICK = 32'h0000_0018;

    localparam int TCON_EN = 0;
    localparam int TCON_IE = 1;
    localparam int TCON_ST = 2;

    localparam int TCON_W   = 3;
    localparam int LED_W    = 8;
    localparam int SWITCH_W = 8;
    localparam int DIGI_W   = 12;

    localparam logic [31:0] TIMER_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_periph_if.sv
// Load/store bus between the EX/MEM pipeline register and the peripheral block.
interface mem_periph_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        memrd;
    logic        memwr;
    logic [31:0] rdata;

    modport master (output addr, output wdata, output memrd, output memwr, input rdata);
    modport slave  (input addr, input wdata, input memrd, input memwr, output rdata);
endinterface

// File: rtl/periph_timer.sv
// Reloading 32-bit timer: TH holds the reload value, TL counts, and TCON holds
// enable, interrupt enable and a sticky status bit.
module periph_timer
    import mem_periph_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_th,
    input  logic              wr_tl,
    input  logic              wr_tcon,
    input  logic [31:0]       wdata,
    output logic [31:0]       th,
    output logic [31:0]       tl,
    output logic [TCON_W-1:0] tcon,
    output logic              irqout
);

    logic [31:0]       th_r;
    logic [31:0]       tl_r;
    logic [TCON_W-1:0] tcon_r;
    logic              ovf_s;

    assign ovf_s = tcon_r[TCON_EN] && (tl_r == TIMER_MAX);

    // reload value register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)     th_r <= 32'h0;
        else if (wr_th) th_r <= wdata;
        else            th_r <= th_r;
    end

    // counter: a software write beats the reload and the increment
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                tl_r <= 32'h0;
        else if (wr_tl)            tl_r <= wdata;
        else if (ovf_s)            tl_r <= th_r;
        else if (tcon_r[TCON_EN])  tl_r <= tl_r + 32'h1;
        else                       tl_r <= tl_r;
    end

    // control/status: status is sticky until software rewrites TCON
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                           tcon_r <= {TCON_W{1'b0}};
        else if (wr_tcon)                     tcon_r <= wdata[TCON_W-1:0];
        else if (ovf_s && tcon_r[TCON_IE])    tcon_r[TCON_ST] <= 1'b1;
        else                                  tcon_r <= tcon_r;
    end

    assign th     = th_r;
    assign tl     = tl_r;
    assign tcon   = tcon_r;
    assign irqout = tcon_r[TCON_ST];

endmodule

// File: rtl/mem_periph.sv
// Memory-mapped peripherals: timer, LEDs, seven-segment, switches and an
// optional free-running SYSTICK counter enabled by MEM_PERIPH_SYSTICK_EN.
module mem_periph
    import mem_periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
)
(
    input  logic                clk,
    input  logic                reset,
    mem_periph_if.slave         bus,
    input  logic [SWITCH_W-1:0] switch,
    output logic [LED_W-1:0]    led,
    output logic [DIGI_W-1:0]   digi,
    output logic                irqout
);

    localparam logic [31:0] A_TH      = BASE_ADDR + OFF_TH;
    localparam logic [31:0] A_TL      = BASE_ADDR + OFF_TL;
    localparam logic [31:0] A_TCON    = BASE_ADDR + OFF_TCON;
    localparam logic [31:0] A_LED     = BASE_ADDR + OFF_LED;
    localparam logic [31:0] A_SWITCH  = BASE_ADDR + OFF_SWITCH;
    localparam logic [31:0] A_DIGI    = BASE_ADDR + OFF_DIGI;
    localparam logic [31:0] A_SYSTICK = BASE_ADDR + OFF_SYSTICK;

    logic [31:0]         th_s;
    logic [31:0]         tl_s;
    logic [TCON_W-1:0]   tcon_s;
    logic [31:0]         systick_s;
    logic [31:0]         rdata_s;
    logic [LED_W-1:0]    led_r;
    logic [DIGI_W-1:0]   digi_r;
    logic [SWITCH_W-1:0] sw_meta_r;
    logic [SWITCH_W-1:0] sw_sync_r;
    logic                wr_th_s;
    logic                wr_tl_s;
    logic                wr_tcon_s;
    logic                wr_led_s;
    logic                wr_digi_s;

    // full-width compare, so unaligned addresses never hit a register
    assign wr_th_s   = bus.memwr && (bus.addr == A_TH);
    assign wr_tl_s   = bus.memwr && (bus.addr == A_TL);
    assign wr_tcon_s = bus.memwr && (bus.addr == A_TCON);
    assign wr_led_s  = bus.memwr && (bus.addr == A_LED);
    assign wr_digi_s = bus.memwr && (bus.addr == A_DIGI);

    periph_timer u_timer (
        .clk     (clk),
        .reset   (reset),
        .wr_th   (wr_th_s),
        .wr_tl   (wr_tl_s),
        .wr_tcon (wr_tcon_s),
        .wdata   (bus.wdata),
        .th      (th_s),
        .tl      (tl_s),
        .tcon    (tcon_s),
        .irqout  (irqout)
    );

    // LED and seven-segment output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led_r  <= {LED_W{1'b0}};
            digi_r <= {DIGI_W{1'b0}};
        end else begin
            led_r  <= wr_led_s  ? bus.wdata[LED_W-1:0]  : led_r;
            digi_r <= wr_digi_s ? bus.wdata[DIGI_W-1:0] : digi_r;
        end
    end

    // two-flop synchronizer for the asynchronous board switches
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta_r <= {SWITCH_W{1'b0}};
            sw_sync_r <= {SWITCH_W{1'b0}};
        end else begin
            sw_meta_r <= switch;
            sw_sync_r <= sw_meta_r;
        end
    end

`ifdef MEM_PERIPH_SYSTICK_EN
    logic        wr_systick_s;
    logic [31:0] systick_r;

    assign wr_systick_s = bus.memwr && (bus.addr == A_SYSTICK);

    // free-running tick counter, wraps naturally at 32 bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            systick_r <= 32'h0;
        else if (wr_systick_s) systick_r <= bus.wdata;
        else                   systick_r <= systick_r + 32'h1;
    end

    assign systick_s = systick_r;
`else
    assign systick_s = 32'h0;
`endif

    // same-cycle read mux; reads always see the pre-write register value
    always_comb begin
        rdata_s = 32'h0;
        if (bus.memrd) begin
            case (bus.addr)
                A_TH:      rdata_s = th_s;
                A_TL:      rdata_s = tl_s;
                A_TCON:    rdata_s = {{(32-TCON_W){1'b0}}, tcon_s};
                A_LED:     rdata_s = {{(32-LED_W){1'b0}}, led_r};
                A_SWITCH:  rdata_s = {{(32-SWITCH_W){1'b0}}, sw_sync_r};
                A_DIGI:    rdata_s = {{(32-DIGI_W){1'b0}}, digi_r};
                A_SYSTICK: rdata_s = systick_s;
                default:   rdata_s = 32'h0;
            endcase
        end else begin
            rdata_s = 32'h0;
        end
    end

    assign bus.rdata = rdata_s;
    assign led       = led_r;
    assign digi      = digi_r;

endmodule

// File: tb/tb_mem_periph.sv
// Scoreboard bench for mem_periph: expected read data is queued when a read is
// driven and compared when the DUT output is sampled on the falling edge.
module tb_mem_periph;

    localparam logic [31:0] B       = 32'h4000_0000;
    localparam logic [31:0] A_TH    = B + 32'h00;
    localparam logic [31:0] A_TL    = B + 32'h04;
    localparam logic [31:0] A_TCON  = B + 32'h08;
    localparam logic [31:0] A_LED   = B + 32'h0C;
    localparam logic [31:0] A_SW    = B + 32'h10;
    localparam logic [31:0] A_DIGI  = B + 32'h14;
    localparam logic [31:0] A_STICK = B + 32'h18;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  switch = 8'h00;
    logic [7:0]  led;
    logic [11:0] digi;
    logic        irqout;
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    mem_periph_if bus_if ();

    mem_periph #(.BASE_ADDR(32'h4000_0000)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus_if),
        .switch (switch),
        .led    (led),
        .digi   (digi),
        .irqout (irqout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%08h exp=%08h", tag, obs, exp);
        end
    endtask

    // one-cycle write; returns 1ns after the committing edge
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.memwr = 1'b1;
        @(posedge clk);
        #1;
        bus_if.memwr = 1'b0;
    endtask

    // one-cycle read with optional strobe; compare at the falling edge
    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp,
                      input logic strobe = 1'b1, input logic also_wr = 1'b0,
                      input logic [31:0] d = 32'h0);
        bus_if.addr  = a;
        bus_if.wdata = d;
        bus_if.memrd = strobe;
        bus_if.memwr = also_wr;
        exp_q.push_back(exp);
        @(negedge clk);
        chk(tag, bus_if.rdata, exp_q.pop_front());
        @(posedge clk);
        #1;
        bus_if.memrd = 1'b0;
        bus_if.memwr = 1'b0;
    endtask

    initial begin
        bus_if.addr  = 32'h0;
        bus_if.wdata = 32'h0;
        bus_if.memrd = 1'b0;
        bus_if.memwr = 1'b0;
        #2;
        chk("rst_led", {24'h0, led}, 32'h0);
        chk("rst_digi", {20'h0, digi}, 32'h0);
        chk("rst_irq", {31'h0, irqout}, 32'h0);
        rd("rst_tl", A_TL, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rd("rst_tcon", A_TCON, 32'h0);
        rd("rst_th", A_TH, 32'h0);

        // timer overflow reloads TH and raises the sticky status
        wr(A_TH, 32'hFFFF_FFFD);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h3);
        rd("s1_tl_fd", A_TL, 32'hFFFF_FFFD);
        rd("s1_tl_fe", A_TL, 32'hFFFF_FFFE);
        chk("s1_irq_lo", {31'h0, irqout}, 32'h0);
        rd("s1_tl_ff", A_TL, 32'hFFFF_FFFF);
        chk("s1_irq_hi", {31'h0, irqout}, 32'h1);
        rd("s1_tl_reload", A_TL, 32'hFFFF_FFFD);
        rd("s1_tcon", A_TCON, 32'h7);

        // clearing status by rewriting TCON wins over a same-edge overflow
        wr(A_TCON, 32'h3);
        chk("s2_irq_clr", {31'h0, irqout}, 32'h0);
        rd("s2_tcon", A_TCON, 32'h3);
        rd("s2_running", A_TL, 32'hFFFF_FFFE);

        // software write to TL beats the increment on the same edge
        wr(A_TL, 32'h10);
        rd("s3_tl_wr", A_TL, 32'h10);
        rd("s3_tl_inc", A_TL, 32'h11);
        wr(A_TCON, 32'h0);

        // LED / DIGI write and truncation, read-during-write returns old value
        wr(A_LED, 32'h1234_565A);
        rd("led_rd", A_LED, 32'h5A);
        chk("led_port", {24'h0, led}, 32'h5A);
        wr(A_DIGI, 32'hFFFF_FABC);
        rd("digi_rd", A_DIGI, 32'hABC);
        chk("digi_port", {20'h0, digi}, 32'hABC);
        rd("rdwr_old", A_LED, 32'h5A, 1'b1, 1'b1, 32'h3C);
        rd("rdwr_new", A_LED, 32'h3C);

        // switch synchronizer latency and read-only behavior
        switch = 8'hA5;
        rd("s4_sw_e0", A_SW, 32'h0);
        rd("s4_sw_e1", A_SW, 32'h0);
        rd("s4_sw_e2", A_SW, 32'hA5);
        wr(A_SW, 32'h12);
        rd("s4_sw_ro", A_SW, 32'hA5);

        // unmapped, unaligned and unstrobed reads; unmapped writes are inert
        rd("s5_unmapped", B + 32'h20, 32'h0);
        rd("s5_unaligned", B + 32'h1, 32'h0);
        rd("s5_no_strobe", A_LED, 32'h0, 1'b0);
        wr(B + 32'h0D, 32'hFF);
        wr(B + 32'h20, 32'hFF);
        rd("s5_led_kept", A_LED, 32'h3C);
`ifdef MEM_PERIPH_SYSTICK_EN
        wr(A_STICK, 32'h100);
        rd("stick_load", A_STICK, 32'h100);
        rd("stick_inc", A_STICK, 32'h101);
        wr(A_STICK, 32'hFFFF_FFFF);
        rd("stick_max", A_STICK, 32'hFFFF_FFFF);
        rd("stick_wrap", A_STICK, 32'h0);
`else
        wr(A_STICK, 32'h100);
        rd("s5_stick_off", A_STICK, 32'h0);
`endif

        // asynchronous reset mid-count clears state without a clock edge
        wr(A_LED, 32'h5A);
        wr(A_TH, 32'h0000_0100);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("s6_irq_pre", {31'h0, irqout}, 32'h1);
        #2;
        reset = 1'b0;
        bus_if.addr  = A_TL;
        bus_if.memrd = 1'b1;
        #1;
        exp_q.push_back(32'h0);
        chk("s6_tl_async", bus_if.rdata, exp_q.pop_front());
        chk("s6_irq_async", {31'h0, irqout}, 32'h0);
        chk("s6_led_async", {24'h0, led}, 32'h0);
        bus_if.memrd = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        rd("s6_led_rd", A_LED, 32'h0);
        rd("s6_tl_rd", A_TL, 32'h0);

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_periph.md
MEM_PERIPH -- requirements
Module: mem_periph

Interface
REQ-001 Parameter: BASE_ADDR, 32'h40000000, base of peripheral address window.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low.
REQ-004 addr  input  32  byte address from the EX/MEM ALU output.
REQ-005 wdata  input  32  store data from the EX/MEM databusB.
REQ-006 memrd  input  1  load strobe from the EX/MEM register.
REQ-007 memwr  input  1  store strobe from the EX/MEM register.
REQ-008 switch  input  8  board switches, asynchronous to clk.
REQ-009 rdata  output  32  load data to the MEM/WB stage.
REQ-010 led  output  8  LED register.
REQ-011 digi  output  12  seven-segment drive register.
REQ-012 irqout  output  1  timer interrupt request to the control unit.

Function
REQ-013 Register map, offsets from BASE_ADDR: 0x00 TH (rw); 0x04 TL (rw); 0x08 TCON[2:0] (rw); 0x0C LED[7:0] (rw); 0x10 SWITCH[7:0] (ro); 0x14 DIGI[11:0] (rw); 0x18 SYSTICK (rw).
REQ-014 Decode: full 32-bit compare of addr against BASE_ADDR+offset; addr[1:0] are part of the compare, so unaligned addresses are unmapped.
REQ-015 Read: rdata is combinational, same cycle; equals the zero-extended register when memrd=1 and addr is mapped, else 32'h0.
REQ-016 Write: when memwr=1 and addr is mapped and writable, the register takes wdata (truncated to its width) on the next rising edge.
REQ-017 Writes to SWITCH or to unmapped addresses are ignored, with no side effects.
REQ-018 memrd and memwr both 1: the read returns the pre-write value and the write commits at the edge.
REQ-019 TCON bit 0 = timer enable, bit 1 = interrupt enable, bit 2 = interrupt status.
REQ-020 Timer, when TCON[0]=1: TL increments by 1 each cycle.
REQ-021 Timer overflow: when TL==32'hFFFFFFFF, TL reloads TH on the next edge, not 0; if TCON[1]=1 the same edge sets TCON[2].
REQ-022 TCON[2] is sticky; only a software write to TCON clears it.
REQ-023 irqout = TCON[2], registered, with no combinational path from inputs.
REQ-024 Same-cycle conflict: a software write to TL or TCON takes priority over the timer increment, reload and status set for that register on that edge.
REQ-025 SWITCH passes through a two-flop synchronizer; a switch change is visible to a read 2 edges after it is sampled.
REQ-026 SYSTICK increments by 1 every cycle and wraps 32'hFFFFFFFF -> 0; a write loads wdata, and increment resumes from the loaded value on the following edge.
REQ-027 led and digi drive directly from their registers.

Reset
REQ-028 Reset asserted: TH=0, TL=0, TCON=0, LED=0, DIGI=0, SYSTICK=0, and both synchronizer flops = 0; consequently irqout=0, led=0, digi=0.
REQ-029 Reset asserted mid-count clears the timer immediately, with no clock edge required.
REQ-030 Reset is applied asynchronously and its release is synchronous to the next edge; the first increment occurs on the first edge after release.

Configuration
REQ-031 Macro MEM_PERIPH_SYSTICK_EN.
REQ-032 MEM_PERIPH_SYSTICK_EN defined: SYSTICK is implemented per REQ-026.
REQ-033 MEM_PERIPH_SYSTICK_EN undefined: no SYSTICK flops exist; offset 0x18 reads 0 and writes to it are ignored.

Structure
REQ-034 Shared package mem_periph_pkg holds the register offset constants, the TCON bit-index constants and the register widths.
REQ-035 Sub-module periph_timer contains TH, TL and TCON, including the overflow, reload, status and write-priority logic; mem_periph contains the decode, read mux, LED, DIGI, switch synchronizer and SYSTICK.

Verification
REQ-036 Scenario 1: write TH=0xFFFFFFFD, TL=0xFFFFFFFD, TCON=3 -> TL sequence FE, FF, reload FD; TCON[2] and irqout set on the reload edge.
REQ-037 Scenario 2: irq pending, write TCON=3 -> irqout drops at the next edge and the timer keeps running.
REQ-038 Scenario 3: write TL=0x10 on the same edge the timer would increment -> TL=0x10, not 0x11.
REQ-039 Scenario 4: switch=0xA5 held -> a read of 0x40000010 returns 0xA5 from the 2nd edge onward and 0 before it; a write to 0x40000010 leaves the value unchanged.
REQ-040 Scenario 5: reads of 0x40000020, 0x40000001, and any mapped address with memrd=0 all return 0; without MEM_PERIPH_SYSTICK_EN, a read of 0x40000018 also returns 0.
REQ-041 Scenario 6: reset pulsed between edges mid-count -> TL=0 and irqout=0 immediately; LED=0x5A written before the pulse reads back 0 after it.
